// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the iterative radix-2 restoring divider.
// The default datapath width and the iteration count are the same number.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_ITERS = 64;
  localparam int CNT_W     = $clog2(DIV_ITERS);

endpackage : seq_divider_pkg

// File: rtl/seq_divider_if.sv
// valid/data_ok handshake between the execute-stage ALU (master) and the divider (slave).
interface seq_divider_if #(
  parameter int WIDTH = 64
);

  logic             valid;
  logic             is_signed;
  logic             flush;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             data_ok;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;

  modport master (
    output valid, is_signed, flush, a, b,
    input  data_ok, quot, rem
  );

  modport slave (
    input  valid, is_signed, flush, a, b,
    output data_ok, quot, rem
  );

endinterface : seq_divider_if

// File: rtl/seq_divider_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and report the quotient bit.
module seq_divider_step #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] r,
  input  logic             din,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_nxt,
  output logic             qbit
);

  logic [WIDTH:0] shifted;

  // The shifted value needs one extra bit for the compare; after the
  // subtraction the result is below d, so the low WIDTH bits are exact.
  always_comb begin
    shifted = {r, din};
    qbit    = (shifted >= {1'b0, d});
    r_nxt   = qbit ? (shifted[WIDTH-1:0] - d) : shifted[WIDTH-1:0];
  end

endmodule : seq_divider_step

// File: rtl/seq_divider.sv
// Iterative signed/unsigned restoring divider, one quotient bit per cycle,
// responding on the valid/data_ok handshake with registered quot/rem.
//
// state | meaning
// IDLE  | waiting for valid; accepts a request when flush is low
// BUSY  | iterating, one quotient bit per cycle over WIDTH cycles
// DONE  | data_ok high for one cycle; always returns to IDLE
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_ITERS
) (
  input  logic           clk,
  input  logic           resetn,
  seq_divider_if.slave   bus
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_t       state;
  div_state_t       state_nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] prem;
  logic             sign_q;
  logic             sign_r;
  logic [WIDTH-1:0] quot_r;
  logic [WIDTH-1:0] rem_r;

  logic             accept;
  logic             div_zero;
  logic             last_iter;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] step_r;
  logic             step_q;
  logic [WIDTH-1:0] q_final;

  assign accept    = (state == IDLE) && bus.valid && !bus.flush;
  assign div_zero  = (bus.b == '0);
  assign last_iter = (state == BUSY) && (cnt == LAST);

  // INT_MIN negates to itself, which read as unsigned is the correct magnitude.
  assign a_mag = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // The dividend register doubles as the quotient register: dividend bits
  // leave at the top while quotient bits enter at the bottom.
  seq_divider_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .r     (prem),
    .din   (dvd[WIDTH-1]),
    .d     (dsr),
    .r_nxt (step_r),
    .qbit  (step_q)
  );

  assign q_final = {dvd[WIDTH-2:0], step_q};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = div_zero ? DONE : BUSY;
      BUSY:    if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt    <= '0;
      dvd    <= '0;
      dsr    <= '0;
      prem   <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      quot_r <= '0;
      rem_r  <= '0;
    end else if (!bus.flush) begin
      if (accept) begin
        if (div_zero) begin
          quot_r <= '1;
          rem_r  <= bus.a;
        end else begin
          dvd    <= a_mag;
          dsr    <= b_mag;
          prem   <= '0;
          cnt    <= '0;
          sign_q <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          sign_r <= bus.is_signed & bus.a[WIDTH-1];
        end
      end else if (state == BUSY) begin
        dvd  <= {dvd[WIDTH-2:0], step_q};
        prem <= step_r;
        cnt  <= cnt + 1'b1;
        if (last_iter) begin
          quot_r <= sign_q ? -q_final : q_final;
          rem_r  <= sign_r ? -step_r  : step_r;
        end
      end
    end
  end

  assign bus.data_ok = (state == DONE);
  assign bus.quot    = quot_r;
  assign bus.rem     = rem_r;

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table plus abort, back-to-back
// and operand-stability sequences, with a result scoreboard.
module tb_seq_divider;

  localparam int W = 64;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    string        nm;
  } exp_t;

  typedef struct {
    string        nm;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sgn;
    int           lat;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } vec_t;

  logic clk;
  logic resetn;
  int   cyc;
  int   compared;
  int   mismatched;
  logic prev_ok;
  exp_t sb[$];
  vec_t vecs[11];

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Result monitor: every data_ok pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (resetn && bus.data_ok) begin
      compared++;
      if (prev_ok) begin
        mismatched++;
        $display("FAIL data_ok_pulse: high in two consecutive cycles at cycle %0d, required single pulse", cyc);
      end
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_data_ok: data_ok at cycle %0d, required none", cyc);
      end else begin
        e = sb.pop_front();
        if (bus.quot !== e.q || bus.rem !== e.r) begin
          mismatched++;
          $display("FAIL result_%s: got quot=%h rem=%h, required quot=%h rem=%h",
                   e.nm, bus.quot, bus.rem, e.q, e.r);
        end
      end
    end
    prev_ok = resetn && bus.data_ok;
  end

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] q, input logic [W-1:0] r, input string nm);
    exp_t e;
    e.q  = q;
    e.r  = r;
    e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic start_cycle(output int c0);
    @(posedge clk);
    #1;
    c0 = cyc;
  endtask

  task automatic to_cycle(input int c0, input int k);
    while (cyc - c0 < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ok(input int c0, output int lat);
    lat = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.data_ok) begin
        lat = cyc - c0;
        break;
      end
    end
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    bus.a         = a;
    bus.b         = b;
    bus.is_signed = s;
    bus.valid     = 1'b1;
  endtask

  // Watchdog so a stuck DUT still ends the run.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int lat;
    int lat2;
    int seen;

    compared   = 0;
    mismatched = 0;
    prev_ok    = 1'b0;
    bus.valid     = 1'b0;
    bus.is_signed = 1'b0;
    bus.flush     = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    resetn        = 1'b0;

    vecs[0]  = '{"u100_7",    64'd100,               64'd7,                 1'b0, 65, 64'd14,                64'd2};
    vecs[1]  = '{"s_m7_2",    64'hFFFF_FFFF_FFFF_FFF9, 64'd2,               1'b1, 65, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[2]  = '{"u_m7_2",    64'hFFFF_FFFF_FFFF_FFF9, 64'd2,               1'b0, 65, 64'h7FFF_FFFF_FFFF_FFFC, 64'd1};
    vecs[3]  = '{"s_min_m1",  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 65, 64'h8000_0000_0000_0000, 64'd0};
    vecs[4]  = '{"s_7_m2",    64'd7,                 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 65, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1};
    vecs[5]  = '{"s_m7_m2",   64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 65, 64'd3,              64'hFFFF_FFFF_FFFF_FFFF};
    vecs[6]  = '{"u_max_1",   64'hFFFF_FFFF_FFFF_FFFF, 64'd1,               1'b0, 65, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
    vecs[7]  = '{"u_max_min", 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0, 65, 64'd1,              64'h7FFF_FFFF_FFFF_FFFF};
    vecs[8]  = '{"u_1_max",   64'd1,                 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 65, 64'd0,              64'd1};
    vecs[9]  = '{"u5_0",      64'd5,                 64'd0,                 1'b0, 1,  64'hFFFF_FFFF_FFFF_FFFF, 64'd5};
    vecs[10] = '{"s_m5_0",    64'hFFFF_FFFF_FFFF_FFFB, 64'd0,               1'b1, 1,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB};

    repeat (3) @(posedge clk);
    #1;
    check("reset_data_ok", W'(bus.data_ok), '0);
    check("reset_quot", bus.quot, '0);
    check("reset_rem", bus.rem, '0);
    @(negedge clk);
    resetn = 1'b1;

    foreach (vecs[i]) begin
      start_cycle(c0);
      drive(vecs[i].a, vecs[i].b, vecs[i].sgn);
      push_exp(vecs[i].q, vecs[i].r, vecs[i].nm);
      wait_ok(c0, lat);
      bus.valid = 1'b0;
      check($sformatf("latency_%s", vecs[i].nm), W'(lat), W'(vecs[i].lat));
    end

    // Flush in cycle 30, new request in cycle 32.
    start_cycle(c0);
    drive(64'd100, 64'd7, 1'b0);
    to_cycle(c0, 30);
    bus.flush = 1'b1;
    to_cycle(c0, 31);
    bus.flush = 1'b0;
    bus.valid = 1'b0;
    check("flush_hold_quot", bus.quot, 64'hFFFF_FFFF_FFFF_FFFF);
    check("flush_hold_rem", bus.rem, 64'hFFFF_FFFF_FFFF_FFFB);
    to_cycle(c0, 32);
    drive(64'd20, 64'd3, 1'b0);
    push_exp(64'd6, 64'd2, "after_flush");
    wait_ok(c0, lat);
    bus.valid = 1'b0;
    check("latency_after_flush", W'(lat), W'(97));

    // Back-to-back with valid held across both requests.
    start_cycle(c0);
    drive(64'd100, 64'd7, 1'b0);
    push_exp(64'd14, 64'd2, "b2b_first");
    wait_ok(c0, lat);
    drive(64'd20, 64'd3, 1'b0);
    push_exp(64'd6, 64'd2, "b2b_second");
    wait_ok(c0, lat2);
    bus.valid = 1'b0;
    check("latency_b2b_first", W'(lat), W'(65));
    check("latency_b2b_second", W'(lat2), W'(131));

    // Operands change right after accept.
    start_cycle(c0);
    drive(64'd100, 64'd7, 1'b0);
    push_exp(64'd14, 64'd2, "stable_ops");
    to_cycle(c0, 1);
    bus.a         = 64'hDEAD_BEEF_0000_1234;
    bus.b         = '0;
    bus.is_signed = 1'b1;
    wait_ok(c0, lat);
    bus.valid = 1'b0;
    check("latency_stable_ops", W'(lat), W'(65));

    // Asynchronous reset mid-operation.
    start_cycle(c0);
    drive(64'd100, 64'd7, 1'b0);
    to_cycle(c0, 40);
    resetn = 1'b0;
    #1;
    check("midreset_data_ok", W'(bus.data_ok), '0);
    check("midreset_quot", bus.quot, '0);
    check("midreset_rem", bus.rem, '0);
    bus.valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.data_ok) seen++;
    end
    check("midreset_no_data_ok", W'(seen), '0);

    start_cycle(c0);
    drive(64'd20, 64'd3, 1'b0);
    push_exp(64'd6, 64'd2, "after_reset");
    wait_ok(c0, lat);
    bus.valid = 1'b0;
    check("latency_after_reset", W'(lat), W'(65));

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", W'(sb.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_seq_divider
